// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - Avalon-MM request/response bundle for one side of the arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                lock;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin Avalon-MM arbiter with lock and read-tag routing
module mem_arbiter #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic          protocol_err
);
    localparam int PTR_W = $clog2(MAX_PENDING);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t           state, state_next;
    logic             owner, owner_next;
    logic             last, last_next;
    logic [PTR_W:0]   pend_cnt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             tag_mem [MAX_PENDING];

    logic req0, req1;
    logic o_read, o_write, o_lock;
    logic read_block, active, complete, push, pop;

    assign req0       = m0.read | m0.write;
    assign req1       = m1.read | m1.write;
    assign o_read     = owner ? m1.read  : m0.read;
    assign o_write    = owner ? m1.write : m0.write;
    assign o_lock     = owner ? m1.lock  : m0.lock;
    assign read_block = o_read && (pend_cnt == (PTR_W+1)'(MAX_PENDING));
    // Outputs are forced quiet while reset is held, whatever state is still registered.
    assign active     = reset && (state == S_OWN);

    always_comb begin
        s.address      = '0;
        s.read         = 1'b0;
        s.write        = 1'b0;
        s.byteenable   = '0;
        s.writedata    = '0;
        s.lock         = 1'b0;
        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        if (active) begin
            s.address    = owner ? m1.address    : m0.address;
            s.byteenable = owner ? m1.byteenable : m0.byteenable;
            s.writedata  = owner ? m1.writedata  : m0.writedata;
            s.read       = o_read & ~read_block;
            s.write      = o_write;
            s.lock       = o_lock;
            if (owner) m1.waitrequest = s.waitrequest | read_block;
            else       m0.waitrequest = s.waitrequest | read_block;
        end
    end

    assign complete = (s.read | s.write) & ~s.waitrequest;
    assign push     = s.read & ~s.waitrequest;
    assign pop      = reset & s.readdatavalid & (pend_cnt != '0);

    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
    assign m0.readdatavalid = pop & ~tag_mem[rd_ptr];
    assign m1.readdatavalid = pop &  tag_mem[rd_ptr];

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        case (state)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_next = S_OWN;
                    owner_next = (req0 & req1) ? ~last : req1;
                    last_next  = owner_next;
                end
            end
            S_OWN: begin
                if ((complete & ~o_lock) | (~o_read & ~o_write & ~o_lock))
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            owner        <= 1'b0;
            last         <= 1'b0;
            pend_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
            if (s.readdatavalid && (pend_cnt == '0)) protocol_err <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid pend_cnt.
    always_ff @(posedge clock) begin
        if (push) tag_mem[wr_ptr] <= owner;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a queue-based reference model
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int MAXP = 4;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          lk;
        logic [25:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } op_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic protocol_err;

    mem_arbiter_if #(.ADDR_W(26), .DATA_W(32)) m0 ();
    mem_arbiter_if #(.ADDR_W(26), .DATA_W(32)) m1 ();
    mem_arbiter_if #(.ADDR_W(26), .DATA_W(32)) s ();

    mem_arbiter #(.ADDR_W(26), .DATA_W(32), .MAX_PENDING(MAXP)) dut (
        .clock(clock),
        .reset(reset),
        .m0(m0),
        .m1(m1),
        .s(s),
        .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    op_t q0[$];
    op_t q1[$];
    int  own = -1;
    int  last = 0;
    int  tagq[$];
    bit  err_m = 1'b0;
    int  grants[$];
    bit  waitq[$];
    int  wait_pct = 0;
    int  rdv_pct = 0;
    bit  rdv_any = 1'b0;
    bit  force_rdv = 1'b0;
    logic [31:0] force_data = '0;
    logic seen_rdv0, seen_rdv1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input bit rd, input bit wr, input bit lk, input int addr, input int data);
        op_t o;
        o.rd = rd; o.wr = wr; o.lk = lk;
        o.addr = 26'(addr); o.data = 32'(data); o.be = 4'hF;
        return o;
    endfunction

    task automatic drive(input int p);
        op_t o;
        o = mk(0, 0, 0, 0, 0);
        if (p == 0 && q0.size() > 0) o = q0[0];
        if (p == 1 && q1.size() > 0) o = q1[0];
        if (p == 0) begin
            m0.read = o.rd; m0.write = o.wr; m0.lock = o.lk;
            m0.address = o.addr; m0.writedata = o.data; m0.byteenable = o.be;
        end else begin
            m1.read = o.rd; m1.write = o.wr; m1.lock = o.lk;
            m1.address = o.addr; m1.writedata = o.data; m1.byteenable = o.be;
        end
    endtask

    // One clock: drive inputs, check outputs at negedge, advance the model at posedge.
    task automatic cycle();
        bit rd[2], wr[2], lk[2], e_wait[2], e_rdv[2];
        bit blocked, e_sread, e_swrite, done;
        int o, nxt;
        drive(0);
        drive(1);
        if (waitq.size() > 0) s.waitrequest = waitq.pop_front();
        else                  s.waitrequest = ($urandom_range(99) < wait_pct);
        if (force_rdv) begin
            s.readdatavalid = 1'b1;
            s.readdata      = force_data;
            force_rdv       = 1'b0;
        end else begin
            s.readdatavalid = (tagq.size() > 0 || rdv_any) && ($urandom_range(99) < rdv_pct);
            s.readdata      = $urandom;
        end
        @(negedge clock);
        rd = '{m0.read, m1.read};
        wr = '{m0.write, m1.write};
        lk = '{m0.lock, m1.lock};
        e_wait = '{1'b1, 1'b1};
        e_rdv  = '{1'b0, 1'b0};
        e_sread = 0; e_swrite = 0; blocked = 0;
        o = own;
        if (reset && own >= 0) begin
            blocked     = rd[o] && (tagq.size() == MAXP);
            e_sread     = rd[o] && !blocked;
            e_swrite    = wr[o];
            e_wait[o]   = s.waitrequest || blocked;
        end
        if (reset && s.readdatavalid && tagq.size() > 0) e_rdv[tagq[0]] = 1'b1;
        chk("s_read", s.read, e_sread);
        chk("s_write", s.write, e_swrite);
        chk("m0_wait", m0.waitrequest, e_wait[0]);
        chk("m1_wait", m1.waitrequest, e_wait[1]);
        chk("m0_rdv", m0.readdatavalid, e_rdv[0]);
        chk("m1_rdv", m1.readdatavalid, e_rdv[1]);
        chk("protocol_err", protocol_err, err_m);
        chk("m0_rdata", m0.readdata, s.readdata);
        chk("m1_rdata", m1.readdata, s.readdata);
        if (reset && own >= 0) begin
            chk("s_address", s.address, (o == 1) ? m1.address : m0.address);
            chk("s_wdata", s.writedata, (o == 1) ? m1.writedata : m0.writedata);
            chk("s_be", s.byteenable, (o == 1) ? m1.byteenable : m0.byteenable);
        end
        seen_rdv0 = m0.readdatavalid;
        seen_rdv1 = m1.readdatavalid;
        @(posedge clock);
        done = reset && own >= 0 && (e_sread || e_swrite) && !s.waitrequest;
        if (!reset) begin
            own = -1; last = 0; tagq.delete(); err_m = 1'b0;
        end else begin
            if (s.readdatavalid) begin
                if (tagq.size() > 0) void'(tagq.pop_front());
                else err_m = 1'b1;
            end
            if (done && e_sread) tagq.push_back(o);
            if (own < 0) begin
                if (rd[0] || wr[0] || rd[1] || wr[1]) begin
                    if ((rd[0] || wr[0]) && (rd[1] || wr[1])) nxt = 1 - last;
                    else nxt = (rd[1] || wr[1]) ? 1 : 0;
                    own = nxt; last = nxt;
                    grants.push_back(nxt);
                end
            end else if ((done && !lk[o]) || (!rd[o] && !wr[o] && !lk[o])) begin
                own = -1;
            end
            if (done) begin
                if (o == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
        #1;
    endtask

    task automatic run_until_empty(input int max);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_left", q0.size() + q1.size(), 0);
    endtask

    task automatic deliver(input logic [31:0] data, input int exp_port);
        force_rdv  = 1'b1;
        force_data = data;
        cycle();
        chk("tag_route", {seen_rdv1, seen_rdv0}, (exp_port == 1) ? 2'b10 : 2'b01);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        s.waitrequest = 0; s.readdatavalid = 0; s.readdata = '0;
        reset = 1'b0;
        cycle();
        cycle();
        chk("reset_m0_wait", m0.waitrequest, 1);
        chk("reset_m1_wait", m1.waitrequest, 1);
        chk("reset_perr", protocol_err, 0);
        reset = 1'b1;

        // single write from port 1
        q1.push_back(mk(0, 1, 0, 'h100, 'h00FF00));
        cycle();
        chk("sw_write_c2", s.write, 1);
        chk("sw_addr_c2", s.address, 'h100);
        chk("sw_wait_c2", m1.waitrequest, 0);
        cycle();
        chk("sw_write_c3", s.write, 0);
        chk("sw_wait_c3", m1.waitrequest, 1);

        // tie right after reset: port 1 first
        do_reset();
        grants.delete();
        q0.push_back(mk(0, 1, 0, 'h10, 'h1111));
        q1.push_back(mk(0, 1, 0, 'h20, 'h2222));
        run_until_empty(20);
        chk("tie_count", grants.size(), 2);
        chk("tie_first", (grants.size() > 0) ? grants[0] : -1, 1);
        chk("tie_second", (grants.size() > 1) ? grants[1] : -1, 0);

        // locked color+depth write with 3 stall cycles, port 0 waiting
        grants.delete();
        q1.push_back(mk(0, 1, 1, 'h200, 'hC0C0));
        q1.push_back(mk(0, 1, 0, 'h204, 'hD0D0));
        waitq = '{1'b0, 1'b1, 1'b1, 1'b1};
        cycle();
        q0.push_back(mk(0, 1, 0, 'h300, 'h3333));
        run_until_empty(30);
        chk("lock_count", grants.size(), 2);
        chk("lock_first", (grants.size() > 0) ? grants[0] : -1, 1);
        chk("lock_second", (grants.size() > 1) ? grants[1] : -1, 0);

        // read tagging: four port-0 reads, then one port-1 read
        for (int i = 0; i < 4; i++) q0.push_back(mk(1, 0, 0, 'h1000 + 4 * i, 0));
        run_until_empty(30);
        deliver('hA, 0);
        q1.push_back(mk(1, 0, 0, 'h2000, 0));
        run_until_empty(10);
        deliver('hB, 0);
        deliver('hC, 0);
        deliver('hD, 0);
        deliver('hE, 1);

        // pending full: fifth read stalls until a response frees a slot
        for (int i = 0; i < 5; i++) q0.push_back(mk(1, 0, 0, 'h3000 + 4 * i, 0));
        for (int i = 0; i < 12; i++) cycle();
        chk("full_queue", q0.size(), 1);
        chk("full_s_read", s.read, 0);
        chk("full_m0_wait", m0.waitrequest, 1);
        deliver('h11, 0);
        chk("full_resume", s.read, 1);
        cycle();
        chk("full_done", q0.size(), 0);
        for (int i = 0; i < 4; i++) deliver(32'h20 + i, 0);

        // response with nothing pending
        force_rdv = 1'b1;
        force_data = 'hDEAD;
        cycle();
        chk("err_no_valid", {seen_rdv1, seen_rdv0}, 2'b00);
        chk("err_set", protocol_err, 1);

        // reset in the middle of a locked, stalled sequence
        q1.push_back(mk(0, 1, 1, 'h400, 'h4444));
        q1.push_back(mk(0, 1, 0, 'h404, 'h5555));
        waitq = '{1'b1, 1'b1, 1'b1, 1'b1};
        cycle(); cycle(); cycle();
        q0.delete(); q1.delete(); waitq.delete();
        do_reset();
        chk("rst_perr", protocol_err, 0);
        chk("rst_m0_wait", m0.waitrequest, 1);
        chk("rst_m1_wait", m1.waitrequest, 1);
        chk("rst_s_write", s.write, 0);

        // randomized traffic
        do_reset();
        wait_pct = 30;
        rdv_pct = 40;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (((p == 0) ? q0.size() : q1.size()) < 3 && $urandom_range(99) < 40) begin
                    op_t a, b;
                    bit r, l;
                    r = $urandom_range(1);
                    l = ($urandom_range(99) < 20);
                    a = mk(r, !r, l, $urandom, $urandom);
                    a.be = 4'($urandom);
                    b = mk(!r, r, 0, $urandom, $urandom);
                    if (p == 0) begin q0.push_back(a); if (l) q0.push_back(b); end
                    else        begin q1.push_back(a); if (l) q1.push_back(b); end
                end
            end
            rdv_any = ($urandom_range(99) < 2);
            cycle();
        end
        rdv_any = 1'b0;
        run_until_empty(300);
        for (int i = 0; i < 50 && tagq.size() > 0; i++) cycle();
        chk("tags_drained", tagq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
